// File: rtl/switch_press_counter.sv
`default_nettype none
// ============================================================================
// Module   : switch_press_counter
// Brief    : Synchronises and debounces a raw push-button, detects debounced
//            presses and keeps a wrapping 4-bit press count for the
//            seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module switch_press_counter #(
    parameter int DEBOUNCE_LIMIT = 500000,
    parameter int WRAP_VALUE     = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sw_i,
    output logic       sw_clean_o,
    output logic [3:0] count_o,
    output logic       count_valid_o,
    output logic       wrap_o
);

    // Debounce counter only has to reach DEBOUNCE_LIMIT-1.
    localparam int              c_cnt_w   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_LIMIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [3:0]      c_wrap    = 4'(WRAP_VALUE);

    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic               r_stable_d;
    logic [c_cnt_w-1:0] r_db_cnt;
    logic [3:0]         r_count;
    logic               r_valid;
    logic               r_wrap;
    logic               w_press;

    // A press is the rising edge of the debounced level; releases are ignored.
    assign w_press = r_stable & ~r_stable_d;

    // Two-flop synchroniser for the asynchronous switch input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= sw_i;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after it has persisted for DEBOUNCE_LIMIT cycles;
    // any return to the accepted level restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stable <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_s2 == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_cnt_max) begin
            r_stable <= r_s2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + c_cnt_one;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    // Wrapping press counter with single-cycle valid and wrap strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= 4'd0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (w_press) begin
            r_valid <= 1'b1;
            if (r_count == c_wrap) begin
                r_count <= 4'd0;
                r_wrap  <= 1'b1;
            end else begin
                r_count <= r_count + 4'd1;
                r_wrap  <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end
    end

    assign sw_clean_o    = r_stable;
    assign count_o       = r_count;
    assign count_valid_o = r_valid;
    assign wrap_o        = r_wrap;

endmodule
`default_nettype wire
